uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter clk_freq_hz, default 25000000, the clock frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 115200, the line rate in bits per second.
REQ-003 SHALL have parameter fifo_depth, default 4, a power of two, the receive FIFO entry count.
REQ-004 SHALL have port i_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_uart_rx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port o_data, output, 8 bits: received byte at the FIFO head.
REQ-008 SHALL have port o_valid, output, 1 bit: FIFO not empty.
REQ-009 SHALL have port i_ready, input, 1 bit: consumer accepts o_data.
REQ-010 SHALL have port o_frame_err, output, 1 bit: one-cycle pulse when a stop bit samples 0.
REQ-011 SHALL have port o_overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-012 SHALL pass i_uart_rx through a 2-flop synchronizer (both flops reset to 1); all later logic uses only the synchronized value rx_s.
REQ-013 SHALL use DIV = clk_freq_hz/baud_rate (integer division; 217 at defaults) and HALF = DIV/2 (108).
REQ-014 SHALL implement the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-015 IDLE: when rx_s == 0, SHALL load the bit counter with HALF-1 and go to START.
REQ-016 START: when the counter reaches 0, SHALL sample rx_s; on 1 (glitch) it SHALL return to IDLE; on 0 it SHALL load DIV-1, clear the bit index and go to DATA.
REQ-017 DATA: at each counter expiry, SHALL shift rx_s into bit[index] (LSB first) and reload DIV-1; after index 7 it SHALL go to STOP.
REQ-018 STOP: at counter expiry, SHALL sample rx_s. On 1, SHALL push the byte and go to IDLE. On 0, SHALL pulse o_frame_err, discard the byte and go to WAIT_HIGH.
REQ-019 WAIT_HIGH: SHALL remain until rx_s == 1, then go to IDLE; this ensures a break condition yields exactly one o_frame_err.
REQ-020 SHALL make o_valid = FIFO not empty, and o_data = head entry when valid, else 8'h00.
REQ-021 SHALL pop the FIFO in any cycle where o_valid && i_ready; pop with i_ready high and FIFO empty SHALL have no effect.
REQ-022 Push is registered: o_valid SHALL rise in the cycle after the stop-bit sample.
REQ-023 Push while full and no pop in the same cycle: SHALL drop the byte, leave the FIFO unchanged and pulse o_overrun.
REQ-024 Simultaneous push and pop while full: SHALL accept both, keep the count unchanged and not pulse o_overrun.
REQ-025 Simultaneous push and pop while empty: SHALL write the new byte; the pop SHALL have no effect.
REQ-026 SHALL let FIFO read and write pointers wrap modulo fifo_depth, using an extra pointer bit to distinguish full from empty.
REQ-027 Receiver FSM SHALL run independently of i_ready; consumer backpressure never stalls line sampling.

Reset
REQ-028 While i_rst is high, SHALL force state IDLE, counter 0, bit index 0, synchronizer flops 1, FIFO pointers 0.
REQ-029 While i_rst is high, SHALL drive o_valid 0, o_data 8'h00, o_frame_err 0 and o_overrun 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no push and no error pulse; reception SHALL resume at the next falling edge after reset deasserts.

Structure
REQ-031 SHALL keep the state encodings and the DIV/HALF derivation in a shared package/include used by both the UART emitter and this receiver.
REQ-032 SHALL instantiate one sub-module, uart_rx_fifo (synchronous FIFO, parameter fifo_depth, width 8), containing the storage, pointers and full/empty logic.
REQ-033 SHALL size the counter as $clog2(DIV) bits.

Verification
REQ-034 Bench SHALL check: defaults, 0x55 sent at DIV=217, i_ready=1 -> o_valid rises within 2063±2 cycles of the line falling edge with o_data=0x55, one-cycle pulse.
REQ-035 Bench SHALL check: 5 bytes 0x01..0x05 back-to-back, i_ready=0 -> 0x01..0x04 held, one o_overrun pulse on byte 5; then i_ready=1 -> pops 0x01,0x02,0x03,0x04 in order, then o_valid=0.
REQ-036 Bench SHALL check: frame 0xA3 with stop bit forced 0 -> one o_frame_err pulse, no push; line held low 5000 cycles -> no further pulses; line high then 0x3C -> 0x3C received.
REQ-037 Bench SHALL check: 40-cycle low glitch on an idle line -> returns to IDLE, no push, no error pulse.
REQ-038 Bench SHALL check: i_rst asserted during bit 4 of 0xFF -> all outputs 0, nothing pushed; next byte 0x81 received correctly.
REQ-039 Bench SHALL check: FIFO full with i_ready=1 in the exact stop-sample cycle -> o_overrun stays 0 and the new byte is queued at the tail.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - shared UART state encodings and bit-timing derivation
package uart_receiver_pkg;

  localparam int DEFAULT_CLK_FREQ_HZ = 25000000;
  localparam int DEFAULT_BAUD_RATE   = 115200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  function automatic int calc_div(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

  function automatic int calc_half(input int clk_freq_hz, input int baud_rate);
    return calc_div(clk_freq_hz, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous receive FIFO with full-drop overrun pulse
module uart_rx_fifo #(
  parameter int fifo_depth = 4,
  parameter int width      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic             valid,
  output logic             overrun
);

  localparam int AW = $clog2(fifo_depth);

  logic [width-1:0] mem [fifo_depth];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  // The extra MSB tells a full ring from an empty one when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign valid = !empty;
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !do_pop;
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling and receive FIFO
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int clk_freq_hz = DEFAULT_CLK_FREQ_HZ,
  parameter int baud_rate   = DEFAULT_BAUD_RATE,
  parameter int fifo_depth  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int DIV  = calc_div(clk_freq_hz, baud_rate);
  localparam int HALF = calc_half(clk_freq_hz, baud_rate);
  localparam int CW   = $clog2(DIV);

  rx_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        sync1;
  logic        rx_s;
  logic        frame_err;
  logic        push;
  logic        pop;
  logic [7:0]  fifo_head;
  logic        fifo_valid;
  logic        fifo_overrun;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= i_uart_rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt   <= CW'(HALF - 1);
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              cnt     <= CW'(DIV - 1);
              bit_idx <= '0;
              state   <= ST_DATA;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            shreg[bit_idx] <= rx_s;
            cnt            <= CW'(DIV - 1);
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          // A held-low line (break) must not retrigger until it returns high.
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign push = (state == ST_STOP) && (cnt == '0) && rx_s;
  assign pop  = o_valid && i_ready;

  uart_rx_fifo #(
    .fifo_depth(fifo_depth),
    .width     (8)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (push),
    .push_data(shreg),
    .pop      (pop),
    .head     (fifo_head),
    .valid    (fifo_valid),
    .overrun  (fifo_overrun)
  );

  assign o_valid     = fifo_valid && !i_rst;
  assign o_data      = i_rst ? 8'h00 : fifo_head;
  assign o_frame_err = frame_err && !i_rst;
  assign o_overrun   = fifo_overrun && !i_rst;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;
  import uart_receiver_pkg::*;

  localparam int DIV = calc_div(DEFAULT_CLK_FREQ_HZ, DEFAULT_BAUD_RATE);

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_fe;
    int         exp_pops;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fall_cyc = -1;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pop_cnt = 0;
  logic [7:0] exp_q[$];

  uart_receiver #(
    .clk_freq_hz(DEFAULT_CLK_FREQ_HZ),
    .baud_rate  (DEFAULT_BAUD_RATE),
    .fifo_depth (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_uart_rx  (uart_rx),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_frame_err(frame_err),
    .o_overrun  (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (valid && ready) begin
        pop_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL pop_unexpected: got %0h expected no byte", data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data !== e) begin
            n_bad++;
            $display("FAIL pop_data: got %0h expected %0h", data, e);
          end
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line is left at the stop-bit level; the caller restores idle if needed.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1;
    uart_rx  = 1'b0;
    fall_cyc = cyc;
    hold(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      hold(DIV);
    end
    uart_rx = stop;
    hold(DIV);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check(name, exp_q.size(), 0);
  endtask

  vec_t vecs[6];
  int   fe0, ov0, pc0, lat;
  logic got;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h55, 1'b1, 0, 1};
    vecs[1] = '{8'h00, 1'b1, 0, 1};
    vecs[2] = '{8'hFF, 1'b1, 0, 1};
    vecs[3] = '{8'hA5, 1'b0, 1, 0};
    vecs[4] = '{8'h5A, 1'b1, 0, 1};
    vecs[5] = '{8'h80, 1'b1, 0, 1};

    hold(4);
    @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_data", data, 0);
    check("reset_fe", frame_err, 0);
    check("reset_ov", overrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready = 1'b1;
    hold(20);

    // Latency from line falling edge to o_valid, and a single-cycle valid.
    exp_q.push_back(8'h55);
    fall_cyc = -1;
    got = 1'b0;
    lat = 0;
    fork
      send_byte(8'h55, 1'b1);
      begin
        wait (fall_cyc >= 0);
        for (int i = 0; i < 3000; i++) begin
          @(negedge clk);
          if (valid) begin
            got = 1'b1;
            lat = cyc - fall_cyc;
            break;
          end
        end
        check("lat_seen", got, 1);
        check("lat_lo", (lat >= 2061) ? 1 : 0, 1);
        check("lat_hi", (lat <= 2065) ? 1 : 0, 1);
        @(negedge clk);
        check("valid_pulse", valid, 0);
      end
    join
    hold(100);

    foreach (vecs[k]) begin
      fe0 = fe_cnt;
      pc0 = pop_cnt;
      if (vecs[k].stop) exp_q.push_back(vecs[k].data);
      send_byte(vecs[k].data, vecs[k].stop);
      uart_rx = 1'b1;
      hold(300);
      check($sformatf("vec%0d_fe", k), fe_cnt - fe0, vecs[k].exp_fe);
      check($sformatf("vec%0d_pops", k), pop_cnt - pc0, vecs[k].exp_pops);
    end

    // Back-to-back bytes into a stalled consumer: fifth byte overruns.
    ready = 1'b0;
    ov0 = ov_cnt;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1);
    end
    hold(300);
    check("ovr_pulses", ov_cnt - ov0, 1);
    check("ovr_queued", exp_q.size(), 4);
    ready = 1'b1;
    wait_drain("ovr_drain", 50);
    @(negedge clk);
    check("ovr_empty", valid, 0);

    // Break: one frame error for a bad stop, then a long low line.
    fe0 = fe_cnt;
    pc0 = pop_cnt;
    send_byte(8'hA3, 1'b0);
    hold(5000);
    check("brk_fe", fe_cnt - fe0, 1);
    check("brk_pops", pop_cnt - pc0, 0);
    uart_rx = 1'b1;
    hold(50);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    hold(300);
    check("brk_fe_after", fe_cnt - fe0, 1);
    check("brk_recover", pop_cnt - pc0, 1);

    // Short low glitch on an idle line.
    fe0 = fe_cnt;
    pc0 = pop_cnt;
    uart_rx = 1'b0;
    hold(40);
    uart_rx = 1'b1;
    hold(400);
    check("glitch_fe", fe_cnt - fe0, 0);
    check("glitch_pops", pop_cnt - pc0, 0);
    check("glitch_valid", valid, 0);

    // Reset mid-frame with a byte already held in the FIFO.
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    hold(50);
    @(negedge clk);
    check("pre_rst_valid", valid, 1);
    check("pre_rst_data", data, 8'h11);
    fe0 = fe_cnt;
    fall_cyc = -1;
    fork
      send_byte(8'hFF, 1'b1);
      begin
        wait (fall_cyc >= 0);
        while (cyc < fall_cyc + 5 * DIV + DIV / 2) hold(1);
        rst = 1'b1;
        hold(3);
        @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_fe", frame_err, 0);
        check("rst_ov", overrun, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    pc0 = pop_cnt;
    ready = 1'b1;
    hold(400);
    check("rst_pops", pop_cnt - pc0, 0);
    check("rst_fe_none", fe_cnt - fe0, 0);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    hold(300);
    check("rst_next", pop_cnt - pc0, 1);

    // Full FIFO, consumer pops in exactly the stop-sample cycle.
    ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(8'h40 + 8'(b));
      send_byte(8'h40 + 8'(b), 1'b1);
    end
    ov0 = ov_cnt;
    pc0 = pop_cnt;
    exp_q.push_back(8'h99);
    fall_cyc = -1;
    fork
      send_byte(8'h99, 1'b1);
      begin
        wait (fall_cyc >= 0);
        while (cyc < fall_cyc + 2063) hold(1);
        ready = 1'b1;
        hold(1);
        ready = 1'b0;
      end
    join
    hold(300);
    check("simul_ov", ov_cnt - ov0, 0);
    check("simul_pops", pop_cnt - pc0, 1);
    check("simul_queued", exp_q.size(), 4);
    ready = 1'b1;
    wait_drain("simul_drain", 50);
    @(negedge clk);
    check("simul_empty", valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
